// File: rtl/yutorina_ctrl_stage_pkg.sv
// Shared definitions for the Yutorina control (commit) stage.
// Holds exception codes, control-op codes, control-register addresses,
// STATUS bit positions and the stage state encoding.
package yutorina_ctrl_stage_pkg;

  typedef enum logic [2:0] {
    EXP_NONE             = 3'd0,
    EXP_INT              = 3'd1,
    EXP_UNDEF_INSN       = 3'd2,
    EXP_OVERFLOW         = 3'd3,
    EXP_LOAD_MISS_ALIGN  = 3'd4,
    EXP_STORE_MISS_ALIGN = 3'd5,
    EXP_TRAP             = 3'd6
  } exp_code_e;

  typedef enum logic [1:0] {
    CTRL_NONE = 2'd0,
    CTRL_WRCR = 2'd1,
    CTRL_ERET = 2'd2
  } ctrl_op_e;

  localparam logic [1:0] CR_STATUS = 2'd0;
  localparam logic [1:0] CR_CAUSE  = 2'd1;
  localparam logic [1:0] CR_EPC    = 2'd2;
  localparam logic [1:0] CR_VECTOR = 2'd3;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_PIE = 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Exception vectors are word aligned; the two low bits never hold state.
  function automatic logic [31:0] vector_align(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/yutorina_ctrl_regs.sv
// Control-register file of the commit stage: STATUS, CAUSE, EPC, VECTOR.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   exp_take        exception taken this cycle (highest priority update)
//   exp_code        code recorded into CAUSE
//   exp_pc          PC recorded into EPC
//   cr_we           CR write (CTRL_WRCR commit)
//   cr_w_addr/data  CR write address / value
//   eret            ERET commit: IE <= PIE
//   cr_r_addr/data  combinational read port (no same-cycle bypass)
//   ie, epc, vector current values used by the top-level decision logic
module yutorina_ctrl_regs
  import yutorina_ctrl_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exp_take,
  input  logic [2:0]  exp_code,
  input  logic [31:0] exp_pc,
  input  logic        cr_we,
  input  logic [1:0]  cr_w_addr,
  input  logic [31:0] cr_w_data,
  input  logic        eret,
  input  logic [1:0]  cr_r_addr,
  output logic [31:0] cr_r_data,
  output logic        ie,
  output logic [31:0] epc,
  output logic [31:0] vector
);

  logic        ie_q, pie_q;
  logic [31:0] cause_q, epc_q, vector_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q     <= 1'b0;
      pie_q    <= 1'b0;
      cause_q  <= '0;
      epc_q    <= '0;
      vector_q <= '0;
    end else if (exp_take) begin
      // An exception preempts any control op carried by the same entry.
      pie_q   <= ie_q;
      ie_q    <= 1'b0;
      cause_q <= {29'b0, exp_code};
      epc_q   <= exp_pc;
    end else if (eret) begin
      ie_q <= pie_q;
    end else if (cr_we) begin
      case (cr_w_addr)
        CR_STATUS: begin
          ie_q  <= cr_w_data[STATUS_IE];
          pie_q <= cr_w_data[STATUS_PIE];
        end
        CR_CAUSE:  cause_q  <= cr_w_data;
        CR_EPC:    epc_q    <= cr_w_data;
        default:   vector_q <= vector_align(cr_w_data);
      endcase
    end
  end

  always_comb begin
    cr_r_data = '0;
    case (cr_r_addr)
      CR_STATUS: cr_r_data = {30'b0, pie_q, ie_q};
      CR_CAUSE:  cr_r_data = cause_q;
      CR_EPC:    cr_r_data = epc_q;
      default:   cr_r_data = vector_q;
    endcase
  end

  assign ie     = ie_q;
  assign epc    = epc_q;
  assign vector = vector_q;

endmodule

// File: rtl/yutorina_ctrl_stage.sv
// Final (commit) stage of the Yutorina CPU.
// Performs GPR write-back, takes exceptions/interrupts at instruction
// boundaries, executes CR writes and ERET, and issues a registered
// one-cycle flush with a redirect PC.
// Ports:
//   clk, rst (async, active-low)
//   mem_*        memory-stage pipeline registers (mem_en_, mem_gpr_we_ active-low)
//   irq          level interrupt request
//   cr_r_addr/cr_r_data  CR read port for the execute stage
//   gpr_we_/gpr_w_addr/gpr_w_data  register-file write port (combinational)
//   flush/new_pc registered redirect to fetch
module yutorina_ctrl_stage
  import yutorina_ctrl_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_,
  input  logic [31:0] mem_pc,
  input  logic [4:0]  mem_w_addr,
  input  logic [31:0] mem_w_data,
  input  logic        mem_gpr_we_,
  input  logic [2:0]  mem_exp_code,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [31:0] mem_out,
  input  logic        irq,
  input  logic [1:0]  cr_r_addr,
  output logic [31:0] cr_r_data,
  output logic        gpr_we_,
  output logic [4:0]  gpr_w_addr,
  output logic [31:0] gpr_w_data,
  output logic        flush,
  output logic [31:0] new_pc
);

  state_e      state_q, state_d;
  logic        flush_q;
  logic [31:0] new_pc_q, new_pc_d;

  logic        commit, take_exp, normal, do_eret, do_wrcr, redirect;
  logic [2:0]  exp_code;
  logic        ie;
  logic [31:0] epc, vector;

  // Entries arriving while in FLUSH are wrong-path and are dropped here.
  assign commit = !mem_en_ && (state_q == ST_RUN);

  // Upstream exceptions outrank the interrupt; irq is only looked at on commit.
  always_comb begin
    exp_code = EXP_NONE;
    if (mem_exp_code != EXP_NONE) exp_code = mem_exp_code;
    else if (irq && ie)           exp_code = EXP_INT;
  end

  assign take_exp = commit && (exp_code != EXP_NONE);
  assign normal   = commit && !take_exp;
  assign do_eret  = normal && (mem_ctrl_op == CTRL_ERET);
  assign do_wrcr  = normal && (mem_ctrl_op == CTRL_WRCR);
  assign redirect = take_exp || do_eret;

  // Write port reads as idle (1/0/0) whenever nothing is retiring normally.
  assign gpr_we_    = normal ? mem_gpr_we_ : 1'b1;
  assign gpr_w_addr = normal ? mem_w_addr  : 5'b0;
  assign gpr_w_data = normal ? mem_out     : 32'b0;

  yutorina_ctrl_regs u_regs (
    .clk       (clk),
    .rst       (rst),
    .exp_take  (take_exp),
    .exp_code  (exp_code),
    .exp_pc    (mem_pc),
    .cr_we     (do_wrcr),
    .cr_w_addr (mem_w_addr[1:0]),
    .cr_w_data (mem_w_data),
    .eret      (do_eret),
    .cr_r_addr (cr_r_addr),
    .cr_r_data (cr_r_data),
    .ie        (ie),
    .epc       (epc),
    .vector    (vector)
  );

  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          state_d  = ST_FLUSH;
          // Pre-edge VECTOR/EPC: a CR write in the previous cycle is visible.
          new_pc_d = take_exp ? vector : epc;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= (state_d == ST_FLUSH);
      new_pc_q <= new_pc_d;
    end
  end

  assign flush  = flush_q;
  assign new_pc = new_pc_q;

endmodule
